sram_port_initiator: RTL

- Request-side controller for one port of the wrapped 64x8 dual-port SRAM macro.
- Accepts valid/ready read/write requests from a client and drives the SRAM port pins CE, WE, A, D and WEM.
- Captures Q after the macro read latency and returns read data on a valid/ready response channel.
- Credit-limited response FIFO: reads are never issued without guaranteed response storage. One instance per SRAM port.

---
 rtl/sram_port_initiator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram_port_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_port_initiator: request-side controller for one SRAM macro port,   |
// | credit-limited read response FIFO. Optional: SRAM_PORT_STATS_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_port_initiator #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  input  logic [DATA_W-1:0] REQ_MASK,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              CE,
  output logic              WE,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] WEM,
  input  logic [DATA_W-1:0] Q
`ifdef SRAM_PORT_STATS_EN
  ,
  output logic [15:0]       RD_CNT,
  output logic [15:0]       WR_CNT,
  output logic [15:0]       STALL_CNT
`endif
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = $clog2(RSP_DEPTH + READ_LATENCY + 2);

  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_credit_ok;
  logic [OCC_W-1:0]        w_occ;
  logic                    r_rd_issue;
  logic [READ_LATENCY-1:0] r_rd_pipe;
  logic [DATA_W-1:0]       r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_fifo_cnt;

  // Every read holds a credit from acceptance until its response is popped.
  always_comb begin
    w_occ = OCC_W'(r_fifo_cnt) + OCC_W'(r_rd_issue);
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_occ = w_occ + OCC_W'(r_rd_pipe[i]);
    end
  end

  assign w_credit_ok = (w_occ < OCC_W'(RSP_DEPTH));
  assign REQ_READY   = RSTN & w_credit_ok;
  assign w_accept    = REQ_VALID & REQ_READY;
  assign w_push      = r_rd_pipe[READ_LATENCY-1];
  assign RSP_VALID   = (r_fifo_cnt != '0);
  assign w_pop       = RSP_VALID & RSP_READY;
  assign RSP_DATA    = r_fifo[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      CE         <= 1'b0;
      WE         <= 1'b0;
      A          <= '0;
      D          <= '0;
      WEM        <= '0;
      r_rd_issue <= 1'b0;
    end else begin
      CE         <= w_accept;
      WE         <= w_accept & REQ_WE;
      r_rd_issue <= w_accept & ~REQ_WE;
      if (w_accept) begin
        A   <= REQ_ADDR;
        D   <= REQ_DATA;
        WEM <= REQ_MASK;
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_pipe_one
      always_ff @(posedge CLK) begin
        if (!RSTN) r_rd_pipe <= '0;
        else       r_rd_pipe <= r_rd_issue;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge CLK) begin
        if (!RSTN) r_rd_pipe <= '0;
        else       r_rd_pipe <= {r_rd_pipe[READ_LATENCY-2:0], r_rd_issue};
      end
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // When full, a simultaneous pop frees the slot the push overwrites.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= Q;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

`ifdef SRAM_PORT_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      RD_CNT    <= '0;
      WR_CNT    <= '0;
      STALL_CNT <= '0;
    end else begin
      if (w_accept && !REQ_WE && (RD_CNT != 16'hFFFF))   RD_CNT    <= RD_CNT + 16'd1;
      if (w_accept && REQ_WE && (WR_CNT != 16'hFFFF))    WR_CNT    <= WR_CNT + 16'd1;
      if (REQ_VALID && !REQ_READY && (STALL_CNT != 16'hFFFF)) STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
